// File: rtl/wb_cmd_master.sv
// Wishbone classic (B4) single-transfer initiator: one command in, one bus cycle, one response out.
// Waits for ack/err on the bus and gives up after a bounded number of strobe cycles.
module wb_cmd_master #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [DATA_W/8-1:0]   cmd_sel_i,
  input  logic [ADDR_W-1:0]     cmd_adr_i,
  input  logic [DATA_W-1:0]     cmd_dat_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_W-1:0]     rsp_dat_o,
  output logic [1:0]            rsp_status_o,
  output logic                  wbm_cyc_o,
  output logic                  wbm_stb_o,
  output logic                  wbm_we_o,
  output logic [DATA_W/8-1:0]   wbm_sel_o,
  output logic [ADDR_W-1:0]     wbm_adr_o,
  output logic [DATA_W-1:0]     wbm_dat_o,
  input  logic [DATA_W-1:0]     wbm_dat_i,
  input  logic                  wbm_ack_i,
  input  logic                  wbm_err_i,
  output logic                  busy_o
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t                state, state_n;
  logic                  ready, ready_n;
  logic                  cyc, cyc_n;
  logic                  we, we_n;
  logic [DATA_W/8-1:0]   sel, sel_n;
  logic [ADDR_W-1:0]     adr, adr_n;
  logic [DATA_W-1:0]     wdat, wdat_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic                  rvalid, rvalid_n;
  logic [DATA_W-1:0]     rdat, rdat_n;
  logic [1:0]            rstat, rstat_n;
  logic                  term;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state  <= IDLE;
      ready  <= 1'b0;
      cyc    <= 1'b0;
      we     <= 1'b0;
      sel    <= '0;
      adr    <= '0;
      wdat   <= '0;
      cnt    <= '0;
      rvalid <= 1'b0;
      rdat   <= '0;
      rstat  <= '0;
    end else begin
      state  <= state_n;
      ready  <= ready_n;
      cyc    <= cyc_n;
      we     <= we_n;
      sel    <= sel_n;
      adr    <= adr_n;
      wdat   <= wdat_n;
      cnt    <= cnt_n;
      rvalid <= rvalid_n;
      rdat   <= rdat_n;
      rstat  <= rstat_n;
    end
  end

  always_comb begin
    state_n  = state;
    cyc_n    = cyc;
    we_n     = we;
    sel_n    = sel;
    adr_n    = adr;
    wdat_n   = wdat;
    cnt_n    = cnt;
    rvalid_n = rvalid;
    rdat_n   = rdat;
    rstat_n  = rstat;
    term     = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid_i) begin
          state_n = BUS;
          cyc_n   = 1'b1;
          we_n    = cmd_we_i;
          sel_n   = cmd_sel_i;
          adr_n   = cmd_adr_i;
          wdat_n  = cmd_dat_i;
          cnt_n   = '0;
        end
      end
      BUS: begin
        // err outranks ack, and ack outranks an expiring timeout on the same edge
        if (wbm_err_i) begin
          term    = 1'b1;
          rstat_n = 2'b01;
          rdat_n  = '0;
        end else if (wbm_ack_i) begin
          term    = 1'b1;
          rstat_n = 2'b00;
          rdat_n  = we ? '0 : wbm_dat_i;
        end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
          term    = 1'b1;
          rstat_n = 2'b10;
          rdat_n  = '0;
        end else if (cnt != '1) begin
          cnt_n = cnt + CW'(1);
        end
        if (term) begin
          state_n  = RESP;
          cyc_n    = 1'b0;
          we_n     = 1'b0;
          sel_n    = '0;
          adr_n    = '0;
          wdat_n   = '0;
          rvalid_n = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_n  = IDLE;
          rvalid_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
    // ready is registered so it stays low through reset and rises the cycle after release
    ready_n = (state_n == IDLE);
  end

  assign cmd_ready_o  = ready;
  assign wbm_cyc_o    = cyc;
  assign wbm_stb_o    = cyc;
  assign wbm_we_o     = we;
  assign wbm_sel_o    = sel;
  assign wbm_adr_o    = adr;
  assign wbm_dat_o    = wdat;
  assign rsp_valid_o  = rvalid;
  assign rsp_dat_o    = rdat;
  assign rsp_status_o = rstat;
  assign busy_o       = (state != IDLE);

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master with TIMEOUT=8; the slave side is driven by hand per test.
module tb_wb_cmd_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [3:0]  cmd_sel = '0;
  logic [31:0] cmd_adr = '0, cmd_dat = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_status;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat, rdata = '0;
  logic        ack = 1'b0, err = 1'b0, busy;

  int n_cmp = 0;
  int n_bad = 0;
  int stb_cnt;

  always #5 clk = ~clk;

  wb_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_sel_i(cmd_sel), .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
    .rsp_status_o(rsp_status),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(wdat), .wbm_dat_i(rdata),
    .wbm_ack_i(ack), .wbm_err_i(err), .busy_o(busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a command, wait (bounded) for ready, and leave the bench in the first BUS cycle
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int guard;
    cmd_valid = 1'b1; cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s;
    guard = 0;
    while (!cmd_ready && guard < 20) begin
      tick;
      guard++;
    end
    chk("issue_ready", cmd_ready, 1'b1);
    tick;
    cmd_valid = 1'b0;
    chk("issue_cyc", cyc, 1'b1);
    chk("issue_adr", adr, a);
  endtask

  // Count strobe cycles; raise ack/err during strobe cycle index 'waits'
  task automatic bus_phase(input int waits, input logic do_ack, input logic do_err,
                           input logic [31:0] d, output int n);
    n = 0;
    for (int i = 0; i < 40 && stb; i++) begin
      n++;
      if (i == waits) begin
        ack = do_ack; err = do_err; rdata = d;
      end
      tick;
      ack = 1'b0; err = 1'b0;
    end
  endtask

  task automatic take_rsp;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk("take_rsp_valid", rsp_valid, 1'b0);
    chk("take_cmd_ready", cmd_ready, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst_n = 1'b0;
    tick; tick;
    chk("rst_cyc", cyc, 1'b0);
    chk("rst_stb", stb, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_adr", adr, 32'h0);
    rst_n = 1'b1;
    tick;
    chk("post_rst_ready", cmd_ready, 1'b1);

    // 1: write, zero-wait slave
    issue(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF);
    chk("t1_stb", stb, 1'b1);
    chk("t1_we", we, 1'b1);
    chk("t1_dat", wdat, 32'hDEAD_BEEF);
    chk("t1_sel", sel, 4'hF);
    chk("t1_busy", busy, 1'b1);
    chk("t1_ready_low", cmd_ready, 1'b0);
    ack = 1'b1; rdata = 32'hFFFF_FFFF;
    tick;
    ack = 1'b0;
    chk("t1_stb_low", stb, 1'b0);
    chk("t1_rsp_valid", rsp_valid, 1'b1);
    chk("t1_status", rsp_status, 2'b00);
    chk("t1_rdat", rsp_dat, 32'h0);
    chk("t1_adr_clr", adr, 32'h0);
    chk("t1_we_clr", we, 1'b0);
    take_rsp;

    // 2: read, 3 wait states
    issue(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    cmd_valid = 1'b1;
    bus_phase(3, 1'b1, 1'b0, 32'h1234_5678, stb_cnt);
    chk("t2_ready_low", cmd_ready, 1'b0);
    cmd_valid = 1'b0;
    chk("t2_stb_cnt", stb_cnt, 4);
    chk("t2_rdat", rsp_dat, 32'h1234_5678);
    chk("t2_status", rsp_status, 2'b00);
    take_rsp;

    // 3: no ack -> timeout after 8 strobe cycles
    issue(1'b0, 32'h3000_0020, 32'h0, 4'h3);
    bus_phase(99, 1'b0, 1'b0, 32'h5555_5555, stb_cnt);
    chk("t3_stb_cnt", stb_cnt, 8);
    chk("t3_status", rsp_status, 2'b10);
    chk("t3_rdat", rsp_dat, 32'h0);
    chk("t3_cyc", cyc, 1'b0);
    take_rsp;

    // 4a: ack and err together -> ERR
    issue(1'b0, 32'h3000_0030, 32'h0, 4'hF);
    bus_phase(1, 1'b1, 1'b1, 32'hCAFE_F00D, stb_cnt);
    chk("t4a_stb_cnt", stb_cnt, 2);
    chk("t4a_status", rsp_status, 2'b01);
    chk("t4a_rdat", rsp_dat, 32'h0);
    take_rsp;

    // 4b: ack on the timeout edge -> OK
    issue(1'b0, 32'h3000_0034, 32'h0, 4'hF);
    bus_phase(7, 1'b1, 1'b0, 32'h0BAD_CAFE, stb_cnt);
    chk("t4b_stb_cnt", stb_cnt, 8);
    chk("t4b_status", rsp_status, 2'b00);
    chk("t4b_rdat", rsp_dat, 32'h0BAD_CAFE);
    take_rsp;

    // 5: backpressure on the response port
    issue(1'b0, 32'h3000_0040, 32'h0, 4'hF);
    bus_phase(0, 1'b1, 1'b0, 32'hA1B2_C3D4, stb_cnt);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0044; cmd_dat = 32'h7777_0000;
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_valid", rsp_valid, 1'b1);
      chk("t5_hold_dat", rsp_dat, 32'hA1B2_C3D4);
      chk("t5_hold_status", rsp_status, 2'b00);
      chk("t5_stall_ready", cmd_ready, 1'b0);
      chk("t5_stall_cyc", cyc, 1'b0);
      tick;
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk("t5_hs_valid", rsp_valid, 1'b0);
    chk("t5_hs_ready", cmd_ready, 1'b1);
    chk("t5_hs_cyc", cyc, 1'b0);
    tick;
    cmd_valid = 1'b0;
    chk("t5_acc_cyc", cyc, 1'b1);
    chk("t5_acc_adr", adr, 32'h3000_0044);
    chk("t5_acc_dat", wdat, 32'h7777_0000);
    bus_phase(0, 1'b1, 1'b0, 32'h0, stb_cnt);
    chk("t5_wr_status", rsp_status, 2'b00);
    take_rsp;

    // 6: reset mid-BUS, then a normal read
    issue(1'b0, 32'h3000_0050, 32'h0, 4'hF);
    tick; tick;
    chk("t6_in_bus", stb, 1'b1);
    rst_n = 1'b0;
    tick;
    chk("t6_rst_cyc", cyc, 1'b0);
    chk("t6_rst_stb", stb, 1'b0);
    chk("t6_rst_rsp_valid", rsp_valid, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_ready", cmd_ready, 1'b0);
    rst_n = 1'b1;
    tick;
    chk("t6_rel_ready", cmd_ready, 1'b1);
    chk("t6_rel_rsp_valid", rsp_valid, 1'b0);
    issue(1'b0, 32'h3000_0060, 32'h0, 4'hF);
    bus_phase(1, 1'b1, 1'b0, 32'hA5A5_5A5A, stb_cnt);
    chk("t6_stb_cnt", stb_cnt, 2);
    chk("t6_rdat", rsp_dat, 32'hA5A5_5A5A);
    chk("t6_status", rsp_status, 2'b00);
    take_rsp;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
